ekf_stage_sched: RTL and testbench
==================================

Name: ekf_stage_sched

Overview:
- Command scheduler in front of the RSA systolic-array engine.
- Queues EKF stage requests (predict, new-landmark init, update) from the host sequencer and issues them one at a time on the RSA one-hot stage_val interface, gated by stage_rdy.
- Tracks each stage through the snooped init_*/done_* handshake and maintains the landmark count and current landmark index driven into RSA.
- Provides a completion pulse, a watchdog timeout and illegal-command rejection.

Parameters:
ROW_LEN, 10, width of landmark_num and l_k
QDEPTH, 4, command FIFO depth (power of 2)
HOLD_CYC, 2, cycles stage_val is held per issue
TO_W, 16, watchdog counter width
TIMEOUT, 1000, cycles allowed in each of WAIT_INIT and WAIT_DONE before abort

Ports:
clk  in  1  clock
sys_rst  in  1  asynchronous active-high reset
req_val  in  1  host command valid
req_stage  in  3  command; one-hot 001 = PRD, 010 = NEW, 100 = UPD
req_lk  in  ROW_LEN  landmark index for UPD (ignored otherwise)
req_rdy  out  1  FIFO not full
stage_val  out  3  to RSA; one-hot stage request
stage_rdy  in  3  from RSA; per-stage ready
init_predict, init_newlm, init_update  in  1 each  snooped RSA stage-start pulses
done_predict, done_newlm, done_update  in  1 each  snooped stage-finish pulses
landmark_num  out  ROW_LEN  to RSA
l_k  out  ROW_LEN  to RSA; index of the active command
busy  out  1  FSM not IDLE
cmpl_val  out  1  one-cycle completion pulse
cmpl_stage  out  3  stage of the completed or aborted command
err_cmd  out  1  one-cycle illegal-command pulse
err_timeout  out  1  sticky watchdog flag; cleared only by reset
q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0, FIFO emptied, FSM to IDLE; req_rdy goes to 1 after release.
  - Reset mid-stage drops the active command with no cmpl_val.
- Accept rule: a command is accepted when req_val & req_rdy. Legal commands are pushed. A command is illegal, and is rejected with err_cmd pulsed the next cycle and no push, if either:
  - req_stage is not one-hot; or
  - it is UPD with req_lk >= landmark_num, where landmark_num is sampled on the accept cycle.
- FIFO:
  - req_rdy = (q_count != QDEPTH).
  - A push and a pop in the same cycle leave q_count unchanged.
  - Pointers wrap modulo QDEPTH.
- FSM states IDLE, ISSUE, WAIT_INIT, WAIT_DONE, RETIRE:
  - IDLE: if FIFO non-empty and stage_rdy & head_stage != 0, pop the head, latch stage (and l_k for UPD; l_k unchanged otherwise), go to ISSUE. Issue latency from push into an empty FIFO with RSA ready: stage_val asserted 2 cycles after the accept edge.
  - ISSUE: stage_val = latched stage for exactly HOLD_CYC cycles, then 0; go to WAIT_INIT.
  - WAIT_INIT: wait for the init_* matching the latched stage, then go to WAIT_DONE. Non-matching init_* and done_* are ignored.
  - WAIT_DONE: wait for the matching done_*, then go to RETIRE. A matching init and done in the same cycle still pass through WAIT_DONE for one cycle.
  - RETIRE (one cycle): cmpl_val = 1, cmpl_stage = latched stage. If NEW, landmark_num increments, saturating at 2^ROW_LEN-1. Return to IDLE.
- Watchdog:
  - Counter clears on entry to WAIT_INIT and again on entry to WAIT_DONE; it increments each cycle in those states.
  - Reaching TIMEOUT sets err_timeout and pulses cmpl_val with cmpl_stage = latched stage.
  - landmark_num is not incremented on abort; FSM returns to IDLE.
  - A matching event on the same cycle as expiry wins over the timeout.
- Ordering: strictly FIFO. A head command whose stage_rdy bit is low blocks all later commands; there is no bypass.
- busy = (state != IDLE). stage_val is never non-zero outside ISSUE.

Test Plan:
- Reset, then push PRD with stage_rdy = 111 -> stage_val = 001 for 2 cycles starting 2 cycles after accept. Pulse init_predict, then 20 cycles later done_predict -> cmpl_val with cmpl_stage = 001 one cycle after done; landmark_num stays 0.
- Push NEW three times with all handshakes returned -> three completions in order; landmark_num = 3; q_count peaks at 2 while the first command is active.
- landmark_num = 3: push UPD with req_lk = 5 -> err_cmd pulse, q_count unchanged. Push UPD with req_lk = 2 -> l_k = 2 during issue, cmpl_stage = 100. Push req_stage = 011 -> err_cmd.
- stage_rdy = 000, push 4 PRD -> req_rdy = 0, a 5th push is not accepted, stage_val stays 0. Raise stage_rdy = 001 -> issue begins and req_rdy returns to 1 after the pop.
- Issue NEW with no init_newlm -> after TIMEOUT cycles err_timeout = 1 (sticky), cmpl_stage = 010, landmark_num unchanged; the next queued command then issues normally.
- Assert sys_rst during WAIT_DONE with 2 commands queued -> outputs 0 immediately, q_count = 0, no cmpl_val; a fresh PRD after release completes normally.

Source files
------------

// File: rtl/ekf_stage_sched.sv
// EKF stage command scheduler: queues PRD/NEW/UPD requests and issues them one at a
// time to the RSA engine, following each through its init/done handshake under a watchdog.
module ekf_stage_sched #(
   parameter int ROW_LEN  = 10,
   parameter int QDEPTH   = 4,
   parameter int HOLD_CYC = 2,
   parameter int TO_W     = 16,
   parameter int TIMEOUT  = 1000
) (
   input  logic                      clk,
   input  logic                      sys_rst,
   input  logic                      req_val,
   input  logic [2:0]                req_stage,
   input  logic [ROW_LEN-1:0]        req_lk,
   output logic                      req_rdy,
   output logic [2:0]                stage_val,
   input  logic [2:0]                stage_rdy,
   input  logic                      init_predict,
   input  logic                      init_newlm,
   input  logic                      init_update,
   input  logic                      done_predict,
   input  logic                      done_newlm,
   input  logic                      done_update,
   output logic [ROW_LEN-1:0]        landmark_num,
   output logic [ROW_LEN-1:0]        l_k,
   output logic                      busy,
   output logic                      cmpl_val,
   output logic [2:0]                cmpl_stage,
   output logic                      err_cmd,
   output logic                      err_timeout,
   output logic [$clog2(QDEPTH):0]   q_count
);
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;
   localparam int HW = $clog2(HOLD_CYC + 1);

   localparam logic [2:0] ST_PRD = 3'b001;
   localparam logic [2:0] ST_NEW = 3'b010;
   localparam logic [2:0] ST_UPD = 3'b100;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_INIT, S_WAIT_DONE, S_RETIRE} state_t;

   state_t             state_q, state_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [TO_W-1:0]    wd_q, wd_d;
   logic [2:0]         stage_q, stage_d, sv_q, sv_d;
   logic [ROW_LEN-1:0] lk_q, lk_d, lm_q, lm_d;
   logic               abort_q, abort_d, done_seen_q, done_seen_d, err_to_q, err_to_d;
   logic               err_cmd_q;

   logic [2:0]         fifo_stage_q [QDEPTH];
   logic [ROW_LEN-1:0] fifo_lk_q    [QDEPTH];
   logic [QW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         head_stage;
   logic [ROW_LEN-1:0] head_lk;
   logic               cmd_legal, accept, push, pop, init_hit, done_hit;

   assign req_rdy    = ~sys_rst & (cnt_q != CW'(QDEPTH));
   assign accept     = req_val & req_rdy;
   assign cmd_legal  = ((req_stage == ST_PRD) || (req_stage == ST_NEW) || (req_stage == ST_UPD))
                       && !((req_stage == ST_UPD) && (req_lk >= lm_q));
   assign push       = accept & cmd_legal;
   assign head_stage = fifo_stage_q[rd_ptr_q];
   assign head_lk    = fifo_lk_q[rd_ptr_q];

   // NOTE: payload storage has no reset; validity is defined solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_stage_q[wr_ptr_q] <= req_stage;
         fifo_lk_q[wr_ptr_q]    <= req_lk;
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         err_cmd_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + QW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + QW'(1);
         cnt_q     <= cnt_q + CW'(push) - CW'(pop);
         err_cmd_q <= accept & ~cmd_legal;
      end
   end

   assign init_hit = |({init_update, init_newlm, init_predict} & stage_q);
   assign done_hit = |({done_update, done_newlm, done_predict} & stage_q);

   // NOTE: every value written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      wd_d        = wd_q;
      stage_d     = stage_q;
      lk_d        = lk_q;
      lm_d        = lm_q;
      abort_d     = abort_q;
      done_seen_d = done_seen_q;
      err_to_d    = err_to_q;
      sv_d        = '0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((cnt_q != '0) && ((stage_rdy & head_stage) != '0)) begin
               pop         = 1'b1;
               stage_d     = head_stage;
               if (head_stage == ST_UPD) lk_d = head_lk;
               hold_d      = '0;
               abort_d     = 1'b0;
               done_seen_d = 1'b0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // stage_val is registered, so it appears one cycle into ISSUE and drops as we leave.
            if (hold_q == HW'(HOLD_CYC)) begin
               wd_d    = '0;
               state_d = S_WAIT_INIT;
            end else begin
               hold_d = hold_q + HW'(1);
               sv_d   = stage_q;
            end
         end
         S_WAIT_INIT: begin
            if (init_hit) begin
               wd_d        = '0;
               done_seen_d = done_hit;
               state_d     = S_WAIT_DONE;
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
               abort_d  = 1'b1;
               err_to_d = 1'b1;
               state_d  = S_RETIRE;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (done_hit || done_seen_q) begin
               done_seen_d = 1'b0;
               state_d     = S_RETIRE;
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
               abort_d  = 1'b1;
               err_to_d = 1'b1;
               state_d  = S_RETIRE;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         S_RETIRE: begin
            if ((stage_q == ST_NEW) && !abort_q && (lm_q != '1)) lm_d = lm_q + ROW_LEN'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         wd_q        <= '0;
         stage_q     <= '0;
         sv_q        <= '0;
         lk_q        <= '0;
         lm_q        <= '0;
         abort_q     <= 1'b0;
         done_seen_q <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         wd_q        <= wd_d;
         stage_q     <= stage_d;
         sv_q        <= sv_d;
         lk_q        <= lk_d;
         lm_q        <= lm_d;
         abort_q     <= abort_d;
         done_seen_q <= done_seen_d;
         err_to_q    <= err_to_d;
      end
   end

   assign stage_val    = sv_q;
   assign landmark_num = lm_q;
   assign l_k          = lk_q;
   assign busy         = (state_q != S_IDLE);
   assign cmpl_val     = (state_q == S_RETIRE);
   assign cmpl_stage   = cmpl_val ? stage_q : 3'b000;
   assign err_cmd      = err_cmd_q;
   assign err_timeout  = err_to_q;
   assign q_count      = cnt_q;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Scoreboard bench for ekf_stage_sched: a driver queues expected completions, an RSA
// responder returns init/done handshakes, and a monitor checks every completion and error.
module tb_ekf_stage_sched;
   localparam int ROW_LEN  = 10;
   localparam int QDEPTH   = 4;
   localparam int HOLD_CYC = 2;
   localparam int TO_W     = 16;
   localparam int TIMEOUT  = 1000;

   localparam logic [2:0] PRD = 3'b001;
   localparam logic [2:0] NEW = 3'b010;
   localparam logic [2:0] UPD = 3'b100;

   logic               clk = 1'b0;
   logic               sys_rst;
   logic               req_val;
   logic [2:0]         req_stage;
   logic [ROW_LEN-1:0] req_lk;
   logic               req_rdy;
   logic [2:0]         stage_val;
   logic [2:0]         stage_rdy;
   logic               init_predict, init_newlm, init_update;
   logic               done_predict, done_newlm, done_update;
   logic [ROW_LEN-1:0] landmark_num, l_k;
   logic               busy, cmpl_val, err_cmd, err_timeout;
   logic [2:0]         cmpl_stage;
   logic [2:0]         q_count;

   ekf_stage_sched #(
      .ROW_LEN(ROW_LEN), .QDEPTH(QDEPTH), .HOLD_CYC(HOLD_CYC), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .sys_rst(sys_rst),
      .req_val(req_val), .req_stage(req_stage), .req_lk(req_lk), .req_rdy(req_rdy),
      .stage_val(stage_val), .stage_rdy(stage_rdy),
      .init_predict(init_predict), .init_newlm(init_newlm), .init_update(init_update),
      .done_predict(done_predict), .done_newlm(done_newlm), .done_update(done_update),
      .landmark_num(landmark_num), .l_k(l_k), .busy(busy),
      .cmpl_val(cmpl_val), .cmpl_stage(cmpl_stage),
      .err_cmd(err_cmd), .err_timeout(err_timeout), .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]         stage;
      logic [ROW_LEN-1:0] lk;
      bit                 abort;
   } item_t;

   item_t              exp_q[$];
   int                 exp_err = 0;
   int                 model_lm = 0;
   logic [ROW_LEN-1:0] model_lk = '0;
   int                 total = 0;
   int                 bad = 0;
   int                 cyc = 0;
   int                 fall_cyc = 0;
   int                 peak_q = 0;

   // responder controls (-1 delay = random)
   bit rsp_en = 1'b1;
   int rsp_init_dly = -1;
   int rsp_done_dly = -1;
   bit rsp_drop_new = 1'b0;
   int rsp_same = 0;
   bit rsp_noise = 1'b0;
   bit rsp_busy = 1'b0;
   bit rsp_in_done = 1'b0;
   int rsp_done_cyc = 0;
   int rsp_lat = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [2:0] s, input logic [ROW_LEN-1:0] lk);
      if ($countones(s) != 1) return 1'b0;
      if (s == UPD && int'(lk) >= model_lm) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send(input logic [2:0] s, input logic [ROW_LEN-1:0] lk, input bit abort);
      int n = 0;
      @(negedge clk);
      while (!req_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_rdy) begin
         check("send_req_rdy", req_rdy, 1);
         return;
      end
      req_val   = 1'b1;
      req_stage = s;
      req_lk    = lk;
      if (is_legal(s, lk)) begin
         if (s == UPD) model_lk = lk;
         exp_q.push_back('{stage: s, lk: model_lk, abort: abort});
      end else begin
         exp_err++;
      end
      @(negedge clk);
      req_val = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (!(!busy && q_count == 0 && exp_q.size() == 0 && !rsp_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_busy"}, busy, 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   initial begin
      item_t      it;
      logic [2:0] prev_sv = '0;
      forever begin
         @(negedge clk);
         if (!sys_rst) begin
            if (int'(q_count) > peak_q) peak_q = int'(q_count);
            if (prev_sv != 3'b000 && stage_val == 3'b000) fall_cyc = cyc;
            if (stage_val != 3'b000) check("stage_val_while_idle", busy, 1);
            if (err_cmd) begin
               check("err_cmd_unexpected", err_cmd, (exp_err > 0));
               if (exp_err > 0) exp_err--;
            end
            if (cmpl_val) begin
               if (exp_q.size() == 0) begin
                  check("cmpl_unexpected", cmpl_val, 0);
               end else begin
                  it = exp_q.pop_front();
                  check("cmpl_stage", cmpl_stage, it.stage);
                  check("cmpl_l_k", l_k, it.lk);
                  check("cmpl_landmark_num", landmark_num, model_lm);
                  if (it.abort) begin
                     check("abort_err_timeout", err_timeout, 1);
                     check("abort_latency", cyc - fall_cyc, TIMEOUT);
                  end else begin
                     check("cmpl_latency", cyc - rsp_done_cyc, rsp_lat);
                  end
                  if (it.stage == NEW && !it.abort && model_lm < (1 << ROW_LEN) - 1) model_lm++;
               end
            end
         end
         prev_sv = stage_val;
      end
   end

   // RSA responder
   initial begin
      logic [2:0] s, nz;
      int         n, d;
      bit         same;
      {init_update, init_newlm, init_predict} = 3'b000;
      {done_update, done_newlm, done_predict} = 3'b000;
      forever begin
         @(negedge clk);
         if (rsp_en && !sys_rst && stage_val != 3'b000) begin
            s = stage_val;
            rsp_busy = 1'b1;
            n = 0;
            while (stage_val != 3'b000 && n < 50) begin
               @(negedge clk);
               n++;
            end
            if (!(rsp_drop_new && s == NEW)) begin
               d = (rsp_init_dly >= 0) ? rsp_init_dly : int'($urandom_range(0, 6));
               repeat (d) @(negedge clk);
               same = (rsp_same == 1) || (rsp_same == 2 && $urandom_range(0, 3) == 0);
               nz = rsp_noise ? (3'($urandom) & ~s) : 3'b000;
               {init_update, init_newlm, init_predict} = s | nz;
               if (same) begin
                  {done_update, done_newlm, done_predict} = s;
                  rsp_done_cyc = cyc;
                  rsp_lat = 2;
               end
               @(negedge clk);
               {init_update, init_newlm, init_predict} = 3'b000;
               {done_update, done_newlm, done_predict} = 3'b000;
               if (!same) begin
                  rsp_in_done = 1'b1;
                  d = (rsp_done_dly >= 0) ? rsp_done_dly : int'($urandom_range(0, 8));
                  repeat (d) @(negedge clk);
                  nz = rsp_noise ? (3'($urandom) & ~s) : 3'b000;
                  {done_update, done_newlm, done_predict} = s | nz;
                  rsp_done_cyc = cyc;
                  rsp_lat = 1;
                  @(negedge clk);
                  {done_update, done_newlm, done_predict} = 3'b000;
                  rsp_in_done = 1'b0;
               end
            end
            rsp_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got timeout, want completion");
      $fatal(1, "time limit");
   end

   // stimulus
   initial begin
      logic [2:0]         s;
      logic [ROW_LEN-1:0] lk;
      int                 n;

      sys_rst   = 1'b1;
      req_val   = 1'b0;
      req_stage = 3'b000;
      req_lk    = '0;
      stage_rdy = 3'b111;
      #1;
      check("rst_req_rdy", req_rdy, 0);
      check("rst_stage_val", stage_val, 0);
      check("rst_busy", busy, 0);
      check("rst_q_count", q_count, 0);
      check("rst_landmark_num", landmark_num, 0);
      check("rst_err_timeout", err_timeout, 0);
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_rdy", req_rdy, 1);

      // single PRD: exact issue window, init then done 20 cycles later
      rsp_init_dly = 0;
      rsp_done_dly = 19;
      send(PRD, '0, 1'b0);
      check("issue_c0", stage_val, 3'b000);
      @(negedge clk);
      check("issue_c1", stage_val, 3'b000);
      @(negedge clk);
      check("issue_c2", stage_val, PRD);
      check("issue_busy", busy, 1);
      @(negedge clk);
      check("issue_c3", stage_val, PRD);
      @(negedge clk);
      check("issue_c4", stage_val, 3'b000);
      wait_idle(200, "prd");
      check("prd_landmark_num", landmark_num, 0);

      // three NEWs back to back
      rsp_init_dly = -1;
      rsp_done_dly = -1;
      rsp_noise    = 1'b1;
      peak_q       = 0;
      repeat (3) send(NEW, '0, 1'b0);
      wait_idle(500, "new3");
      check("new3_landmark_num", landmark_num, 3);
      check("new3_q_peak", peak_q, 2);

      // UPD legality against landmark_num
      send(UPD, 10'd5, 1'b0);
      check("upd_bad_q_count", q_count, 0);
      @(negedge clk);
      check("upd_bad_err_seen", exp_err, 0);
      send(UPD, 10'd2, 1'b0);
      send(3'b011, '0, 1'b0);
      wait_idle(300, "upd");
      check("upd_err_seen", exp_err, 0);
      check("upd_l_k", l_k, 2);

      // randomized single commands
      rsp_same = 2;
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: s = PRD;
            1: s = NEW;
            2: s = UPD;
            default: s = 3'($urandom);
         endcase
         lk = ROW_LEN'($urandom_range(0, model_lm + 1));
         stage_rdy = 3'($urandom_range(1, 7)) | (($countones(s) == 1) ? s : 3'b000);
         send(s, lk, 1'b0);
         wait_idle(300, "rand");
      end
      check("rand_landmark_num", landmark_num, model_lm);
      rsp_same  = 0;
      stage_rdy = 3'b111;

      // full FIFO with the head blocked
      stage_rdy = 3'b000;
      repeat (4) send(PRD, '0, 1'b0);
      check("full_q_count", q_count, 4);
      check("full_req_rdy", req_rdy, 0);
      req_val   = 1'b1;
      req_stage = PRD;
      @(negedge clk);
      req_val = 1'b0;
      check("full_5th_q_count", q_count, 4);
      check("full_stage_val", stage_val, 0);
      check("full_busy", busy, 0);
      stage_rdy = 3'b001;
      @(negedge clk);
      check("unblock_q_count", q_count, 3);
      check("unblock_req_rdy", req_rdy, 1);
      wait_idle(500, "full");
      stage_rdy = 3'b111;

      // watchdog abort on NEW, following PRD issues normally
      n = model_lm;
      rsp_drop_new = 1'b1;
      send(NEW, '0, 1'b1);
      send(PRD, '0, 1'b0);
      wait_idle(3000, "timeout");
      rsp_drop_new = 1'b0;
      check("timeout_sticky", err_timeout, 1);
      check("timeout_landmark_num", landmark_num, n);

      // reset during WAIT_DONE with two commands queued
      rsp_done_dly = 300;
      repeat (3) send(PRD, '0, 1'b0);
      n = 0;
      while (!rsp_in_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("pre_rst_q_count", q_count, 2);
      check("pre_rst_busy", busy, 1);
      sys_rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_q_count", q_count, 0);
      check("mid_rst_cmpl_val", cmpl_val, 0);
      check("mid_rst_err_timeout", err_timeout, 0);
      check("mid_rst_landmark_num", landmark_num, 0);
      exp_q.delete();
      exp_err  = 0;
      model_lm = 0;
      model_lk = '0;
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;
      n = 0;
      while (rsp_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("rsp_quiet", rsp_busy, 0);
      rsp_done_dly = -1;
      send(PRD, '0, 1'b0);
      wait_idle(300, "post_rst");
      check("final_err_pending", exp_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
